// File: rtl/tm1638_responder_pkg.sv
// Shared types for the TM1638 device-side responder: FSM states and command-byte fields.
package tm1638_responder_types;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_DATA = 3'd2,
    RD_DATA = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int unsigned BIT_READ    = 1;
  localparam int unsigned BIT_FIXED   = 2;
  localparam int unsigned BIT_DISP_ON = 3;

endpackage

// File: rtl/tm1638_responder_if.sv
// STB/CLK/DIO link between a TM1638 controller (master) and the device end (slave).
interface tm1638_responder_if;
  logic stb;
  logic sclk;
  logic dio;
  logic resp;
  logic resp_en;

  modport master (output stb, output sclk, output dio, input resp, input resp_en);
  modport slave  (input stb, input sclk, input dio, output resp, output resp_en);
endinterface

// File: rtl/tm1638_responder_sync.sv
// Synchronizes the asynchronous STB/CLK/DIO lines into the system clock and
// produces single-cycle CLK-rise and STB-rise/fall strobes.
module tm1638_responder_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic stb_async,
  input  logic sclk_async,
  input  logic dio_async,
  output logic stb,
  output logic dio,
  output logic sclk_rise,
  output logic stb_rise,
  output logic stb_fall
);

  logic [SYNC_STAGES-1:0] stb_sr;
  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] dio_sr;
  logic                   stb_q;
  logic                   sclk_q;

  // Left unreset on purpose: the chain keeps tracking the live lines through a
  // reset, so releasing reset mid-frame cannot fabricate an STB edge.
  always_ff @(posedge clk) begin
    stb_sr  <= {stb_sr[SYNC_STAGES-2:0], stb_async};
    sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk_async};
    dio_sr  <= {dio_sr[SYNC_STAGES-2:0], dio_async};
    stb_q   <= stb_sr[SYNC_STAGES-1];
    sclk_q  <= sclk_sr[SYNC_STAGES-1];
  end

  assign stb       = stb_sr[SYNC_STAGES-1];
  assign dio       = dio_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_q;
  assign stb_rise  = stb & ~stb_q;
  assign stb_fall  = ~stb & stb_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-end responder: decodes commands, holds display RAM, returns key bytes.
// Optional saturating error counter output enabled by TM1638_RESPONDER_ERR_CNT_EN.
module tm1638_responder
  import tm1638_responder_types::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned READ_BYTES  = 4,
  parameter int unsigned RAM_DEPTH   = 16
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  tm1638_responder_if.slave            spi,
  input  logic [8*READ_BYTES-1:0]      i_Keys,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_Ram_Rd_Addr,
  output logic [7:0]                   o_Ram_Rd_Data,
  output logic                         o_Wr_Valid,
  output logic [$clog2(RAM_DEPTH)-1:0] o_Wr_Addr,
  output logic [7:0]                   o_Wr_Data,
  output logic                         o_Display_On,
  output logic [2:0]                   o_Brightness,
  output logic [2:0]                   o_Diag_State
`ifdef TM1638_RESPONDER_ERR_CNT_EN
  ,
  output logic [7:0]                   o_Err_Cnt
`endif
);

  localparam int unsigned AW  = $clog2(RAM_DEPTH);
  localparam int unsigned RW  = 8 * READ_BYTES;
  localparam int unsigned RCW = $clog2(RW);

  state_t          state;
  state_t          state_nxt;
  logic            stb;
  logic            dio;
  logic            sclk_rise;
  logic            stb_rise;
  logic            stb_fall;
  logic [2:0]      bit_cnt;
  logic [6:0]      sh_in;
  logic [7:0]      rx_byte;
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   ptr_inc;
  logic            fixed_addr;
  logic [RW-1:0]   tx_sh;
  logic [RCW-1:0]  rd_cnt;
  logic            dio_en;
  logic [7:0]      ram [RAM_DEPTH];

  logic bit_strobe;
  logic abort;
  logic byte_done;
  logic cmd_done;
  logic wr_done;
  logic rd_enter;
  logic rd_shift;
  logic rd_last;

  tm1638_responder_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (i_Clk),
    .stb_async (spi.stb),
    .sclk_async(spi.sclk),
    .dio_async (spi.dio),
    .stb       (stb),
    .dio       (dio),
    .sclk_rise (sclk_rise),
    .stb_rise  (stb_rise),
    .stb_fall  (stb_fall)
  );

  // sh_in keeps the previous 7 bits; the arriving bit completes the byte, LSB first.
  assign rx_byte = {dio, sh_in};
  assign ptr_inc = (ptr == AW'(RAM_DEPTH - 1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stb_fall) begin
      state_nxt = CMD;
    end else if (stb_rise) begin
      state_nxt = IDLE;
    end else if (cmd_done) begin
      case (rx_byte[7:6])
        CMD_DATA: state_nxt = rx_byte[BIT_READ] ? RD_DATA : IGNORE;
        CMD_ADDR: state_nxt = WR_DATA;
        default:  state_nxt = IGNORE;
      endcase
    end else if (rd_last) begin
      state_nxt = IGNORE;
    end
  end

  // A fall seen outside IDLE is handled as a rise (abort) followed by a fresh CMD.
  always_comb begin
    bit_strobe   = sclk_rise && !stb && !stb_fall;
    abort        = stb_rise || stb_fall;
    byte_done    = bit_strobe && (bit_cnt == 3'd7) && (state == CMD || state == WR_DATA);
    cmd_done     = byte_done && (state == CMD);
    wr_done      = byte_done && (state == WR_DATA);
    rd_enter     = cmd_done && (rx_byte[7:6] == CMD_DATA) && rx_byte[BIT_READ];
    rd_shift     = bit_strobe && (state == RD_DATA);
    rd_last      = rd_shift && (rd_cnt == RCW'(RW - 1));
    o_Diag_State = state;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bit_cnt      <= '0;
      sh_in        <= '0;
      ptr          <= '0;
      fixed_addr   <= 1'b0;
      tx_sh        <= '0;
      rd_cnt       <= '0;
      dio_en       <= 1'b0;
      o_Wr_Valid   <= 1'b0;
      o_Wr_Addr    <= '0;
      o_Wr_Data    <= '0;
      o_Display_On <= 1'b0;
      o_Brightness <= '0;
    end else begin
      o_Wr_Valid <= 1'b0;
      if (abort) begin
        bit_cnt <= '0;
        dio_en  <= 1'b0;
      end else begin
        if (bit_strobe && (state == CMD || state == WR_DATA)) begin
          sh_in   <= rx_byte[7:1];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (cmd_done) begin
          case (rx_byte[7:6])
            CMD_DATA: fixed_addr <= rx_byte[BIT_FIXED];
            CMD_ADDR: ptr <= rx_byte[AW-1:0];
            CMD_CTRL: begin
              o_Display_On <= rx_byte[BIT_DISP_ON];
              o_Brightness <= rx_byte[2:0];
            end
            default: ;
          endcase
        end
        if (wr_done) begin
          o_Wr_Valid <= 1'b1;
          o_Wr_Addr  <= ptr;
          o_Wr_Data  <= rx_byte;
          if (!fixed_addr) ptr <= ptr_inc;
        end
        if (rd_enter) begin
          tx_sh  <= i_Keys;
          rd_cnt <= '0;
          dio_en <= 1'b1;
        end else if (rd_shift) begin
          tx_sh  <= {1'b0, tx_sh[RW-1:1]};
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_last) dio_en <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int unsigned i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
      o_Ram_Rd_Data <= '0;
    end else begin
      if (wr_done) ram[ptr] <= rx_byte;
      o_Ram_Rd_Data <= ram[i_Ram_Rd_Addr];
    end
  end

  assign spi.resp    = tx_sh[0] & dio_en;
  assign spi.resp_en = dio_en;

`ifdef TM1638_RESPONDER_ERR_CNT_EN
  logic partial;
  logic err_evt;

  assign partial = (state == CMD || state == WR_DATA) && (bit_cnt != '0);
  assign err_evt = (abort && partial) || (cmd_done && (rx_byte[7:6] == CMD_NONE));

  always_ff @(posedge i_Clk) begin
    if (i_Rst)                           o_Err_Cnt <= '0;
    else if (err_evt && o_Err_Cnt != '1) o_Err_Cnt <= o_Err_Cnt + 8'd1;
  end
`endif

endmodule
